// File: rtl/rom_loader_if.sv
// Byte-stream input, program-memory write port and loader status, bundled
// between a host (master) and the rom_loader block (slave).
interface rom_loader_if #(
   parameter int WIDTH      = 32,
   parameter int ADDR_WIDTH = 16
);
   logic                  start;
   logic [7:0]            rx_data;
   logic                  rx_valid;
   logic [ADDR_WIDTH-1:0] address_rom;
   logic [WIDTH-1:0]      data_in_rom;
   logic                  wren_rom;
   logic                  cores_hold;
   logic                  busy;
   logic                  load_done;
   logic                  load_error;

   modport master (
      output start, rx_data, rx_valid,
      input  address_rom, data_in_rom, wren_rom, cores_hold, busy, load_done, load_error
   );

   modport slave (
      input  start, rx_data, rx_valid,
      output address_rom, data_in_rom, wren_rom, cores_hold, busy, load_done, load_error
   );
endinterface

// File: rtl/rom_loader.sv
// Receives a length-prefixed, MSB-first byte stream and writes it word by word
// into program memory, keeping the cores in reset until the load completes.
module rom_loader #(
   parameter int WIDTH      = 32,
   parameter int ADDR_WIDTH = 16,
   parameter int TIMEOUT    = 50000
) (
   input  logic        clk,
   input  logic        rst_n,
   rom_loader_if.slave bus
);
   localparam int BYTES = WIDTH / 8;
   localparam int BC_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam int GAP_W = $clog2(TIMEOUT + 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LEN_HI = 3'd1;
   localparam logic [2:0] S_LEN_LO = 3'd2;
   localparam logic [2:0] S_DATA   = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;
   localparam logic [2:0] S_ERROR  = 3'd5;

   logic [2:0]            state;
   logic [15:0]           word_len;
   logic [15:0]           word_idx;
   logic [BC_W-1:0]       byte_cnt;
   logic [GAP_W-1:0]      gap_cnt;
   logic [WIDTH-1:0]      asm_word;
   logic                  last_wr;

   logic                  vld_p1;
   logic [ADDR_WIDTH-1:0] wr_addr_p1;
   logic [WIDTH-1:0]      wr_data_p1;

   logic [WIDTH-1:0]      asm_next;
   logic                  word_end;
   logic                  gap_expired;

   function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] word,
                                                 input logic [7:0]       b);
      return WIDTH'({word, b});
   endfunction

   assign asm_next    = shift_in(asm_word, bus.rx_data);
   assign word_end    = (byte_cnt == BC_W'(BYTES - 1));
   // Fires on the silent cycle that brings the idle count up to TIMEOUT.
   assign gap_expired = (gap_cnt == GAP_W'(TIMEOUT - 1));

   // Stage p0: byte acceptance, word assembly and sequencing
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         word_len   <= '0;
         word_idx   <= '0;
         byte_cnt   <= '0;
         gap_cnt    <= '0;
         asm_word   <= '0;
         last_wr    <= 1'b0;
         vld_p1     <= 1'b0;
         wr_addr_p1 <= '0;
         wr_data_p1 <= '0;
      end else begin
         vld_p1 <= 1'b0;
         case (state)
            S_IDLE, S_DONE, S_ERROR: begin
               if (bus.start) begin
                  state    <= S_LEN_HI;
                  word_idx <= '0;
                  byte_cnt <= '0;
                  gap_cnt  <= '0;
                  asm_word <= '0;
                  last_wr  <= 1'b0;
               end
            end
            S_LEN_HI: begin
               if (bus.rx_valid) begin
                  word_len[15:8] <= bus.rx_data;
                  gap_cnt        <= '0;
                  state          <= S_LEN_LO;
               end else if (gap_expired) begin
                  state <= S_ERROR;
               end else begin
                  gap_cnt <= gap_cnt + GAP_W'(1);
               end
            end
            S_LEN_LO: begin
               if (bus.rx_valid) begin
                  word_len[7:0] <= bus.rx_data;
                  gap_cnt       <= '0;
                  state         <= ({word_len[15:8], bus.rx_data} == 16'd0) ? S_DONE : S_DATA;
               end else if (gap_expired) begin
                  state <= S_ERROR;
               end else begin
                  gap_cnt <= gap_cnt + GAP_W'(1);
               end
            end
            S_DATA: begin
               // The final write is on the bus this cycle; finish alongside it.
               if (last_wr) begin
                  state   <= S_DONE;
                  last_wr <= 1'b0;
               end else if (bus.rx_valid) begin
                  asm_word <= asm_next;
                  gap_cnt  <= '0;
                  if (word_end) begin
                     byte_cnt   <= '0;
                     vld_p1     <= 1'b1;
                     wr_addr_p1 <= ADDR_WIDTH'(word_idx);
                     wr_data_p1 <= asm_next;
                     word_idx   <= word_idx + 16'd1;
                     if (word_idx == word_len - 16'd1) last_wr <= 1'b1;
                  end else begin
                     byte_cnt <= byte_cnt + BC_W'(1);
                  end
               end else if (gap_expired) begin
                  state <= S_ERROR;
               end else begin
                  gap_cnt <= gap_cnt + GAP_W'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Stage p1: memory write port
   assign bus.wren_rom    = vld_p1;
   assign bus.address_rom = wr_addr_p1;
   assign bus.data_in_rom = wr_data_p1;

   assign bus.busy       = (state == S_LEN_HI) || (state == S_LEN_LO) || (state == S_DATA);
   assign bus.load_done  = (state == S_DONE);
   assign bus.load_error = (state == S_ERROR);
   assign bus.cores_hold = (state != S_DONE);
endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader: a byte-stream model predicts writes and status
// per cycle, and literal expectations pin the key timing points.
module tb_rom_loader;
   localparam int TO = 16;
   localparam int PH_IDLE = 0, PH_LOAD = 1, PH_DONE = 2, PH_ERR = 3;

   typedef struct { int at; int ph; } ev_t;
   typedef struct { int at; logic [15:0] addr; logic [31:0] data; } wr_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;

   rom_loader_if #(.WIDTH(32), .ADDR_WIDTH(16)) bus ();

   rom_loader #(.WIDTH(32), .ADDR_WIDTH(16), .TIMEOUT(TO)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Model state: logical load phase plus scheduled visible effects.
   int          m_ph = PH_IDLE;
   int          m_nbytes, m_len, m_gap, m_words;
   logic [31:0] m_word;
   ev_t         ev_q[$];
   wr_t         wr_q[$];
   int          vis_ph = PH_IDLE;

   // Observations gathered by the compare process.
   int          wr_count, last_wr_cyc, first_done_cyc, first_err_cyc;
   logic        prev_done = 1'b0, prev_err = 1'b0;
   logic [31:0] seen_mem [16];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic model_step(input logic s, input logic v, input logic [7:0] d);
      if (m_ph != PH_LOAD) begin
         if (s) begin
            m_ph = PH_LOAD; m_nbytes = 0; m_gap = 0; m_words = 0; m_len = 0; m_word = '0;
            ev_q.push_back('{cyc + 1, PH_LOAD});
         end
      end else if (v) begin
         m_gap = 0;
         if (m_nbytes < 2) begin
            m_len = (m_len << 8) | int'(d);
            if (m_nbytes == 1 && m_len == 0) begin
               m_ph = PH_DONE;
               ev_q.push_back('{cyc + 1, PH_DONE});
            end
         end else begin
            m_word = {m_word[23:0], d};
            if ((m_nbytes - 2) % 4 == 3) begin
               wr_q.push_back('{cyc + 1, 16'(m_words), m_word});
               m_words++;
               if (m_words == m_len) begin
                  m_ph = PH_DONE;
                  ev_q.push_back('{cyc + 2, PH_DONE});
               end
            end
         end
         m_nbytes++;
      end else begin
         m_gap++;
         if (m_gap == TO) begin
            m_ph = PH_ERR;
            ev_q.push_back('{cyc + 1, PH_ERR});
         end
      end
   endtask

   task automatic model_reset();
      m_ph = PH_IDLE;
      vis_ph = PH_IDLE;
      ev_q.delete();
      wr_q.delete();
   endtask

   task automatic drive(input logic s, input logic v, input logic [7:0] d);
      bus.start = s; bus.rx_valid = v; bus.rx_data = d;
      model_step(s, v, d);
      @(posedge clk); #1;
      bus.start = 1'b0; bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
   endtask

   task automatic send(input logic [7:0] d);
      drive(1'b0, 1'b1, d);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00);
   endtask

   task automatic clear_obs();
      wr_count = 0; last_wr_cyc = -1; first_done_cyc = -1; first_err_cyc = -1;
      for (int i = 0; i < 16; i++) seen_mem[i] = '0;
   endtask

   always @(negedge clk) begin
      while (ev_q.size() > 0 && ev_q[0].at <= cyc) begin
         vis_ph = ev_q[0].ph;
         void'(ev_q.pop_front());
      end
      check("busy", bus.busy, vis_ph == PH_LOAD);
      check("cores_hold", bus.cores_hold, vis_ph != PH_DONE);
      check("load_done", bus.load_done, vis_ph == PH_DONE);
      check("load_error", bus.load_error, vis_ph == PH_ERR);
      if (wr_q.size() > 0 && wr_q[0].at == cyc) begin
         check("wren", bus.wren_rom, 64'd1);
         check("address_rom", bus.address_rom, wr_q[0].addr);
         check("data_in_rom", bus.data_in_rom, wr_q[0].data);
         void'(wr_q.pop_front());
      end else begin
         check("wren_idle", bus.wren_rom, 64'd0);
      end
      if (bus.wren_rom === 1'b1) begin
         wr_count++;
         last_wr_cyc = cyc;
         seen_mem[bus.address_rom[3:0]] = bus.data_in_rom;
      end
      if (bus.load_done && !prev_done) first_done_cyc = cyc;
      if (bus.load_error && !prev_err) first_err_cyc = cyc;
      prev_done = bus.load_done;
      prev_err  = bus.load_error;
   end

   initial begin
      int k;
      bus.start = 1'b0; bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
      clear_obs();
      @(posedge clk); #1;
      check("rst_addr", bus.address_rom, 64'd0);
      check("rst_data", bus.data_in_rom, 64'd0);
      check("rst_wren", bus.wren_rom, 64'd0);
      check("rst_busy", bus.busy, 64'd0);
      check("rst_done", bus.load_done, 64'd0);
      check("rst_error", bus.load_error, 64'd0);
      check("rst_hold", bus.cores_hold, 64'd1);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // Basic two-word load, back-to-back bytes
      clear_obs();
      drive(1'b1, 1'b0, 8'h00);
      send(8'h00); send(8'h02);
      send(8'h12); send(8'h34); send(8'h56); send(8'h78);
      send(8'h9A); send(8'hBC); send(8'hDE);
      k = cyc; send(8'hF0);
      idle(3);
      check("basic_count", wr_count, 64'd2);
      check("basic_word0", seen_mem[0], 64'h12345678);
      check("basic_word1", seen_mem[1], 64'h9ABCDEF0);
      check("basic_wr_lat", last_wr_cyc, k + 1);
      check("basic_done_lat", first_done_cyc, last_wr_cyc + 1);
      check("basic_hold", bus.cores_hold, 64'd0);

      // Empty program
      clear_obs();
      drive(1'b1, 1'b0, 8'h00);
      send(8'h00);
      k = cyc; send(8'h00);
      idle(2);
      check("empty_count", wr_count, 64'd0);
      check("empty_done_lat", first_done_cyc, k + 1);

      // Timeout with a partial word
      clear_obs();
      drive(1'b1, 1'b0, 8'h00);
      send(8'h00); send(8'h01); send(8'hAA);
      k = cyc; send(8'hBB);
      idle(20);
      check("to_err_lat", first_err_cyc, k + 17);
      check("to_count", wr_count, 64'd0);
      check("to_hold", bus.cores_hold, 64'd1);
      check("to_busy", bus.busy, 64'd0);

      // Restart from ERROR; stray starts in DATA; a gap one short of timeout
      clear_obs();
      drive(1'b1, 1'b0, 8'h00);
      send(8'h00); send(8'h02); send(8'hA1);
      idle(5);
      drive(1'b1, 1'b1, 8'hB2);
      idle(3);
      drive(1'b1, 1'b0, 8'h00);
      send(8'hC3);
      idle(TO - 1);
      send(8'hD4);
      send(8'h01); send(8'h02); send(8'h03); send(8'h04);
      idle(3);
      check("ctl_count", wr_count, 64'd2);
      check("ctl_word0", seen_mem[0], 64'hA1B2C3D4);
      check("ctl_word1", seen_mem[1], 64'h01020304);
      check("ctl_done", bus.load_done, 64'd1);

      // Reset mid-word
      clear_obs();
      drive(1'b1, 1'b0, 8'h00);
      send(8'h00); send(8'h03); send(8'h11); send(8'h22);
      #1 rst_n = 1'b0;
      model_reset();
      #1;
      check("mid_rst_wren", bus.wren_rom, 64'd0);
      check("mid_rst_addr", bus.address_rom, 64'd0);
      check("mid_rst_data", bus.data_in_rom, 64'd0);
      check("mid_rst_busy", bus.busy, 64'd0);
      check("mid_rst_hold", bus.cores_hold, 64'd1);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      send(8'h33); send(8'h44); send(8'h55);
      idle(2);
      check("mid_rst_count", wr_count, 64'd0);

      // Load to DONE, then reload a one-word program
      drive(1'b1, 1'b0, 8'h00);
      send(8'h00); send(8'h01);
      send(8'h55); send(8'h66); send(8'h77); send(8'h88);
      idle(2);
      check("pre_reload_done", bus.load_done, 64'd1);
      clear_obs();
      drive(1'b1, 1'b0, 8'h00);
      check("reload_done_fall", bus.load_done, 64'd0);
      check("reload_hold_rise", bus.cores_hold, 64'd1);
      send(8'h00); send(8'h01);
      send(8'h11); send(8'h22); send(8'h33); send(8'h44);
      idle(3);
      check("reload_count", wr_count, 64'd1);
      check("reload_word0", seen_mem[0], 64'h11223344);
      check("reload_done", bus.load_done, 64'd1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/rom_loader.md
ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 Parameter WIDTH, default 32, instruction word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 16 (WIDTH/2), program-memory write-port address width.
REQ-003 Parameter TIMEOUT, default 50000, maximum idle cycles allowed between bytes during a load.
REQ-004 Port list, one line each: name, direction, width, meaning.
- clk, in, 1: single clock for all logic; also drives the memory write port.
- rst_n, in, 1: reset, asynchronous and active-low.
- start, in, 1: one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERROR.
- rx_data, in, 8: incoming program byte.
- rx_valid, in, 1: one-cycle strobe qualifying rx_data.
- address_rom, out, ADDR_WIDTH: write address to the program memory.
- data_in_rom, out, WIDTH: write data to the program memory.
- wren_rom, out, 1: write enable, one-cycle pulse per word.
- cores_hold, out, 1: holds the cores in reset while high.
- busy, out, 1: high while a load is in progress.
- load_done, out, 1: high after a successful load, until the next start.
- load_error, out, 1: high after a timeout, until the next start.

Function
REQ-005 The stream format SHALL be a 2-byte word count N (MSB first), followed by N words of WIDTH/8 bytes each (MSB first).
REQ-006 The FSM SHALL have states IDLE, LEN_HI, LEN_LO, DATA, DONE and ERROR.
REQ-007 The FSM transitions SHALL be:
- IDLE/DONE/ERROR --start--> LEN_HI.
- LEN_HI --byte--> LEN_LO.
- LEN_LO --byte--> DATA, or --> DONE if N=0.
- DATA --last byte of word N-1--> DONE.
REQ-008 rx_valid SHALL be ignored in IDLE, DONE and ERROR.
REQ-009 Bytes SHALL shift into a WIDTH-bit assembly register: new byte in bits [7:0], older bytes shift up.
REQ-010 The cycle after the final byte of a word is accepted, wren_rom SHALL be 1 for exactly one cycle:
- address_rom = word index (0..N-1).
- data_in_rom = assembled word.
REQ-011 address_rom and data_in_rom SHALL be stable during the wren_rom cycle; the word index SHALL increment after the write.
REQ-012 A byte arriving in the same cycle as wren_rom SHALL be accepted as byte 0 of the next word with no loss; back-to-back rx_valid at full clock rate SHALL be supported.
REQ-013 DONE SHALL be entered in the cycle of the last write, so that load_done rises one cycle after the last wren_rom pulse; cores_hold SHALL fall in the same cycle load_done rises.
REQ-014 busy SHALL be 1 in LEN_HI, LEN_LO and DATA, and 0 otherwise.
REQ-015 cores_hold SHALL be 1 in IDLE, LEN_HI, LEN_LO, DATA and ERROR, and 0 only in DONE.
REQ-016 The gap counter SHALL reset to 0 on every accepted byte and on entry to LEN_HI, and SHALL count cycles while busy.
REQ-017 When the gap counter reaches TIMEOUT, the FSM SHALL go to ERROR:
- load_error = 1.
- No further writes; any partial word is discarded.
- Words already written remain in memory.
REQ-018 start asserted while busy SHALL be ignored.
REQ-019 start in DONE or ERROR SHALL clear load_done, load_error, the word index and the assembly register, and SHALL raise cores_hold the next cycle.
REQ-020 wren_rom SHALL never be asserted outside the write cycles of REQ-010.

Reset
REQ-021 On rst_n=0 the block SHALL, asynchronously:
- enter IDLE;
- drive address_rom=0, data_in_rom=0, wren_rom=0, busy=0, load_done=0, load_error=0, cores_hold=1;
- clear all counters.
REQ-022 Reset asserted mid-load SHALL abort the load immediately with no further wren_rom pulse; rst_n deassertion SHALL take effect on the next clk rising edge.

Verification
REQ-023 Basic load: start; bytes 00 02 | 12 34 56 78 | 9A BC DE F0, back-to-back -> two wren_rom pulses:
- addr 0 = 0x12345678, addr 1 = 0x9ABCDEF0.
- load_done=1 and cores_hold=0 one cycle after the second pulse.
REQ-024 Empty program: start; bytes 00 00 -> no wren_rom pulse; load_done=1 in the cycle after the second byte.
REQ-025 Timeout: TIMEOUT=16; start; 00 01 AA BB, then silence -> load_error=1 17 cycles after the BB byte; no wren_rom; cores_hold stays 1.
REQ-026 Mid-load control:
- Second start during DATA -> ignored; the load completes normally.
- rst_n pulsed low mid-word -> outputs take reset values at once; no write occurs.
REQ-027 Reload: after a DONE, start plus a 1-word stream 00 01 11 22 33 44 -> load_done falls and cores_hold rises the cycle after start; write addr 0 = 0x11223344; load_done=1 again.
